// File: rtl/plru_victim_sel_pkg.sv
// Shared tree-PLRU definitions.
//   plru_dir_t     : direction stored in a node bit (which subtree holds the victim)
//   plru_node_idx  : heap index of the node visited at a given level on the path to a way
package plru_victim_sel_pkg;

    typedef enum logic {
        LOWER = 1'b0,
        UPPER = 1'b1
    } plru_dir_t;

    // Heap order: level l starts at node (2^l - 1); the offset within the
    // level is the way index with its (ww - l) low bits dropped.
    function automatic int plru_node_idx(input int level, input int way, input int ww);
        return ((1 << level) - 1) + (way >> (ww - level));
    endfunction

endpackage

// File: rtl/plru_victim_sel_if.sv
// Controller <-> PLRU unit bundle.
//   master: cache control FSM (drives requests and touches, receives victim)
//   slave : plru_victim_sel
interface plru_victim_sel_if #(
    parameter int WAYS = 4,
    parameter int SETS = 8
);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);

    logic            victim_req;
    logic [IW-1:0]   victim_set;
    logic [WAYS-1:0] valid_vec;
    logic [WAYS-1:0] lock_vec;
    logic            victim_ack;
    logic [WW-1:0]   victim_way;
    logic            victim_none;
    logic            touch;
    logic [IW-1:0]   touch_set;
    logic [WW-1:0]   touch_way;

    modport master (
        output victim_req, victim_set, valid_vec, lock_vec,
        output touch, touch_set, touch_way,
        input  victim_ack, victim_way, victim_none
    );

    modport slave (
        input  victim_req, victim_set, valid_vec, lock_vec,
        input  touch, touch_set, touch_way,
        output victim_ack, victim_way, victim_none
    );
endinterface

// File: rtl/plru_victim_sel_tree_walk.sv
// plru_tree_walk: combinational lock-aware walk of one set's PLRU tree.
//   node_bits : WAYS-1 node bits, heap order
//   lock      : ways excluded from replacement
//   way       : selected way (0 when none)
//   none      : every way locked
module plru_tree_walk
    import plru_victim_sel_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int WW  = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] node_bits,
    input  logic [WAYS-1:0] lock,
    output logic [WW-1:0]   way,
    output logic            none
);

    int        idx;
    logic      lo_lk;
    logic      hi_lk;
    plru_dir_t dir;

    always_comb begin
        idx   = 0;
        lo_lk = 1'b1;
        hi_lk = 1'b1;
        dir   = LOWER;
        for (int l = 0; l < WW; l++) begin
            // Children of the current node cover way groups 2*idx and
            // 2*idx+1 at granularity 2^(WW-1-l).
            lo_lk = 1'b1;
            hi_lk = 1'b1;
            for (int j = 0; j < WAYS; j++) begin
                if ((j >> (WW - 1 - l)) == 2 * idx)     lo_lk = lo_lk & lock[j];
                if ((j >> (WW - 1 - l)) == 2 * idx + 1) hi_lk = hi_lk & lock[j];
            end
            dir = LOWER;
            for (int n = 0; n < WAYS - 1; n++)
                if (n == (1 << l) - 1 + idx) dir = plru_dir_t'(node_bits[n]);
            // Steer away from a fully locked subtree.
            if (dir == LOWER && lo_lk)      dir = UPPER;
            else if (dir == UPPER && hi_lk) dir = LOWER;
            idx = 2 * idx + ((dir == UPPER) ? 1 : 0);
        end
        none = &lock;
        way  = none ? '0 : WW'(idx);
    end

endmodule

// File: rtl/plru_victim_sel.sv
// plru_victim_sel: per-set tree pseudo-LRU state and registered victim select.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of plru_victim_sel_if (victim request/result, touch)
// Victim priority: lowest free (invalid and unlocked) way, else lock-aware
// tree walk, else victim_none. A same-cycle touch to the requested set is
// folded into the lookup.
module plru_victim_sel
    import plru_victim_sel_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8,
    localparam int IW  = $clog2(SETS),
    localparam int WW  = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    plru_victim_sel_if.slave  bus
);

    logic [SETS-1:0][WAYS-2:0] node_q, node_d;
    logic                      ack_q, ack_d;
    logic [WW-1:0]             way_q, way_d;
    logic                      none_q, none_d;

    logic [WAYS-2:0] touched;
    logic [WAYS-2:0] lookup_bits;
    logic [WAYS-1:0] free_vec;
    logic [WW-1:0]   free_way;
    logic [WW-1:0]   walk_way;
    logic            walk_none;

    // Post-touch node bits for touch_set: path nodes point away from touch_way.
    always_comb begin
        touched = node_q[bus.touch_set];
        for (int n = 0; n < WAYS - 1; n++)
            for (int l = 0; l < WW; l++)
                if (plru_node_idx(l, int'(bus.touch_way), WW) == n)
                    touched[n] = ~bus.touch_way[WW-1-l];
    end

    always_comb begin
        node_d = node_q;
        if (bus.touch) node_d[bus.touch_set] = touched;
    end

    assign lookup_bits = (bus.touch && bus.touch_set == bus.victim_set)
                       ? touched : node_q[bus.victim_set];

    assign free_vec = ~bus.valid_vec & ~bus.lock_vec;

    always_comb begin
        free_way = '0;
        for (int j = WAYS - 1; j >= 0; j--)
            if (free_vec[j]) free_way = WW'(j);
    end

    plru_tree_walk #(.WAYS(WAYS)) u_walk (
        .node_bits (lookup_bits),
        .lock      (bus.lock_vec),
        .way       (walk_way),
        .none      (walk_none)
    );

    always_comb begin
        ack_d  = bus.victim_req;
        way_d  = way_q;
        none_d = none_q;
        if (bus.victim_req) begin
            if (|free_vec) begin
                way_d  = free_way;
                none_d = 1'b0;
            end else begin
                way_d  = walk_way;
                none_d = walk_none;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_q <= '0;
            ack_q  <= 1'b0;
            way_q  <= '0;
            none_q <= 1'b0;
        end else begin
            node_q <= node_d;
            ack_q  <= ack_d;
            way_q  <= way_d;
            none_q <= none_d;
        end
    end

    assign bus.victim_ack  = ack_q;
    assign bus.victim_way  = way_q;
    assign bus.victim_none = none_q;

endmodule
